cpu_boot_loader: RTL

Upstream boot stage for the single-cycle CPU: receives a framed program image as a byte stream over a valid/ready handshake, writes it word by word into instruction memory, verifies a checksum, then drives the CPU's `initPC` and releases it to run. While loading, `cpu_run` holds the CPU in its reset state (the CPU's `reset` is low-active-to-run). A bad frame parks the block in an error state until reset.

---
 rtl/cpu_boot_loader.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/cpu_boot_loader.sv
// Boot stage for the single-cycle CPU: takes a framed program image as a byte stream,
// writes it word by word into instruction memory, checks the checksum, then releases the CPU.
module cpu_boot_loader #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic [31:0]       init_pc,
  output logic              cpu_run,
  output logic              boot_error,
  output logic              busy
);

  localparam int unsigned MAX_WORDS = 32'd1 << ADDR_W;
  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  typedef enum logic [2:0] {SYNC, HDR, DATA, CSUM, RUN, ERR} state_t;

  state_t            state;
  state_t            nextState;

  logic              accept;
  logic [2:0]        hdrCnt;
  logic [1:0]        byteCnt;
  logic [15:0]       wordTotal;
  logic [15:0]       wordCnt;
  logic [7:0]        sum;
  logic [7:0]        sumNext;
  logic [23:0]       partial;
  logic [31:0]       pcReg;
  logic [ADDR_W-1:0] addr;
  logic [15:0]       nFull;
  logic              hdrBad;
  logic              lastWord;

  assign accept   = rx_valid && rx_ready;
  assign sumNext  = sum + rx_data;
  // On the 6th header byte the word count is only complete once rx_data is folded in.
  assign nFull    = {wordTotal[7:0], rx_data};
  assign hdrBad   = (pcReg[1:0] != 2'b00) || (32'(nFull) > MAX_WORDS);
  assign lastWord = (wordCnt + 16'd1) == wordTotal;
  assign init_pc  = pcReg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= SYNC;
    end else begin
      state <= nextState;
    end
  end

  always_comb begin
    nextState = state;
    case (state)
      SYNC: begin
        if (accept && rx_data == SYNC_BYTE) begin
          nextState = HDR;
        end
      end
      HDR: begin
        if (accept && hdrCnt == 3'd5) begin
          if (hdrBad) begin
            nextState = ERR;
          end else if (nFull == 16'd0) begin
            nextState = CSUM;
          end else begin
            nextState = DATA;
          end
        end
      end
      DATA: begin
        if (accept && byteCnt == 2'd3 && lastWord) begin
          nextState = CSUM;
        end
      end
      CSUM: begin
        if (accept) begin
          nextState = (sumNext == 8'd0) ? RUN : ERR;
        end
      end
      default: nextState = state;
    endcase
  end

  // rx_ready is masked by reset so nothing can be taken while reset is held.
  always_comb begin
    rx_ready   = 1'b0;
    busy       = 1'b0;
    cpu_run    = 1'b0;
    boot_error = 1'b0;
    case (state)
      SYNC: rx_ready = !reset;
      HDR, DATA, CSUM: begin
        rx_ready = !reset;
        busy     = 1'b1;
      end
      RUN: cpu_run = 1'b1;
      ERR: boot_error = 1'b1;
      default: rx_ready = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hdrCnt     <= 3'd0;
      byteCnt    <= 2'd0;
      wordTotal  <= 16'd0;
      wordCnt    <= 16'd0;
      sum        <= 8'd0;
      partial    <= 24'd0;
      pcReg      <= 32'd0;
      addr       <= '0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= 32'd0;
    end else begin
      imem_we <= 1'b0;
      if (accept) begin
        case (state)
          SYNC: begin
            if (rx_data == SYNC_BYTE) begin
              hdrCnt    <= 3'd0;
              byteCnt   <= 2'd0;
              wordTotal <= 16'd0;
              wordCnt   <= 16'd0;
              sum       <= 8'd0;
              partial   <= 24'd0;
              pcReg     <= 32'd0;
            end
          end
          HDR: begin
            sum    <= sumNext;
            hdrCnt <= hdrCnt + 3'd1;
            if (hdrCnt < 3'd4) begin
              pcReg <= {pcReg[23:0], rx_data};
            end else begin
              wordTotal <= {wordTotal[7:0], rx_data};
            end
            if (hdrCnt == 3'd5) begin
              addr <= pcReg[ADDR_W+1:2];
            end
          end
          DATA: begin
            sum     <= sumNext;
            byteCnt <= byteCnt + 2'd1;
            if (byteCnt == 2'd3) begin
              imem_we    <= 1'b1;
              imem_addr  <= addr;
              imem_wdata <= {partial, rx_data};
              addr       <= addr + 1'b1;
              wordCnt    <= wordCnt + 16'd1;
            end else begin
              partial <= {partial[15:0], rx_data};
            end
          end
          CSUM: sum <= sumNext;
          default: sum <= sum;
        endcase
      end
    end
  end

endmodule
